// File: rtl/uart_fifo_transceiver.sv
// 8N1 UART transceiver with a FIFO on each side; tx start bit leaves 2 cycles after a push into an idle serializer.
// Pushes into a full TX FIFO and received bytes that arrive while the RX FIFO is full are dropped.

module uart_fifo_transceiver_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO still lands if the same cycle frees a slot.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)
      count_nxt = count + 1'b1;
    else if (!do_wr && do_rd)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_CNT);
    end
  end

  assign rd_dat = empty ? '0 : mem[rd_ptr];
endmodule

module uart_fifo_transceiver #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUFFER_SIZE  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    tx,
  input  logic                    tx_write,
  input  logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    tx_full,
  output logic                    tx_empty,
  input  logic                    rx_read,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_empty,
  output logic                    rx_full,
  output logic                    rx_break
);
  localparam int CPB  = CLK_FREQ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int BW   = (PAYLOAD_BITS > 2) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [BW-1:0] IDX_END  = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t               rx_state;
  logic                    rx_meta;
  logic                    rx_sync;
  logic                    rx_prev;
  logic [CW-1:0]           rx_cnt;
  logic [BW-1:0]           rx_idx;
  logic [PAYLOAD_BITS-1:0] rx_shreg;
  logic                    rx_push;

  tx_state_t               tx_state;
  logic [CW-1:0]           tx_cnt;
  logic [BW-1:0]           tx_idx;
  logic [PAYLOAD_BITS-1:0] tx_shreg;
  logic [PAYLOAD_BITS-1:0] tx_head;
  logic                    tx_pop;

  uart_fifo_transceiver_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (tx_write),
    .wr_dat (tx_data),
    .rd_en  (tx_pop),
    .rd_dat (tx_head),
    .empty  (tx_empty),
    .full   (tx_full)
  );

  uart_fifo_transceiver_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(BUFFER_SIZE)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (rx_push),
    .wr_dat (rx_shreg),
    .rd_en  (rx_read),
    .rd_dat (rx_data),
    .empty  (rx_empty),
    .full   (rx_full)
  );

  // Start needs a high-to-low transition, so a line held low after a break is not re-read as frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
      rx_push  <= 1'b0;
      rx_break <= 1'b0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_push  <= 1'b0;
      rx_break <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rx_sync && rx_prev)
            rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_sync, rx_shreg[PAYLOAD_BITS-1:1]};
            if (rx_idx == IDX_END)
              rx_state <= RX_STOP;
            else
              rx_idx <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync)
              rx_push <= 1'b1;
            else if (rx_shreg == '0)
              rx_break <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign tx_pop = (tx_state == TX_IDLE) && !tx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shreg <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx <= 1'b1;
          if (!tx_empty) begin
            tx_shreg <= tx_head;
            tx_state <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx       <= 1'b0;
          tx_cnt   <= '0;
          tx_state <= TX_START;
        end
        TX_START: begin
          if (tx_cnt == BIT_END) begin
            tx       <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_idx == IDX_END) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx       <= tx_shreg[0];
              tx_shreg <= tx_shreg >> 1;
              tx_idx   <= tx_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_transceiver.sv
// Bench for uart_fifo_transceiver at 10 cycles/bit and 4-deep FIFOs, line decoded by an independent monitor.
module tb_uart_fifo_transceiver;
  localparam int CPB = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       tx;
  logic       tx_write;
  logic [7:0] tx_data;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_break;

  int checks = 0;
  int failures = 0;
  int tx_ferr = 0;
  int break_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_model[$];
  logic [7:0] mon_b;

  always #5 clk = ~clk;

  uart_fifo_transceiver #(
    .CLK_FREQ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .BUFFER_SIZE(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx),
    .tx_write(tx_write), .tx_data(tx_data), .tx_full(tx_full), .tx_empty(tx_empty),
    .rx_read(rx_read), .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_break(rx_break)
  );

  always @(posedge clk) if (rx_break === 1'b1) break_cnt <= break_cnt + 1;

  // Line monitor: decodes 8N1 frames from tx by mid-bit sampling.
  initial begin
    forever begin
      @(negedge tx);
      if (reset !== 1'b0) continue;
      repeat (CPB/2) @(posedge clk);
      #1;
      if (tx !== 1'b0) continue;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 mon_b[i] = tx;
      end
      repeat (CPB) @(posedge clk);
      #1;
      if (tx !== 1'b1) tx_ferr++;
      tx_q.push_back(mon_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tx_push(input logic [7:0] d);
    tx_write = 1'b1;
    tx_data = d;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_b);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_b;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic rx_pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(rx_data), 32'(exp));
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic expect_tx(input string tag);
    int n = 0;
    while (tx_q.size() < exp_q.size() && n < exp_q.size() * 120 + 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_count"}, 32'(tx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < tx_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(tx_q[i]), 32'(exp_q[i]));
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_tx_low(input string tag);
    int n = 0;
    while (tx !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(tx), 32'(0));
  endtask

  initial begin
    int lowc;
    int k;
    int occ;
    logic [7:0] d;
    logic good;

    reset = 1'b1; rx = 1'b1; tx_write = 1'b0; tx_data = 8'h00; rx_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_flags", 32'({tx, tx_empty, tx_full, rx_empty, rx_full, rx_break}), 32'(6'b110100));
      check("reset_rx_data", 32'(rx_data), 32'(0));
      tx_write = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
    end
    tx_write = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("reset_writes_ignored", 32'(tx_empty), 32'(1));

    // Single byte 0xA5 with exact start-bit length.
    tx_push(8'hA5);
    check("a5_queued", 32'(tx_empty), 32'(0));
    @(negedge clk);
    check("a5_popped", 32'(tx_empty), 32'(1));
    wait_tx_low("a5_start_seen");
    lowc = 0;
    while (tx === 1'b0 && lowc < 40) begin
      lowc++;
      @(negedge clk);
    end
    check("a5_start_len", 32'(lowc), 32'(CPB));
    exp_q.push_back(8'hA5);
    expect_tx("a5");

    // Single received byte 0x3C.
    send_rx(8'h3C, 1'b1);
    check("rx3c_not_empty", 32'(rx_empty), 32'(0));
    rx_pop_check("rx3c_data", 8'h3C);
    check("rx3c_empty_after_read", 32'(rx_empty), 32'(1));

    // TX overflow while serializer is busy: FIFO model with capacity DEPTH, no pops meanwhile.
    tx_push(8'hC3);
    exp_q.push_back(8'hC3);
    repeat (10) @(negedge clk);
    occ = 0;
    for (int v = 1; v <= 5; v++) begin
      tx_push(8'(v));
      if (occ < DEPTH) begin
        exp_q.push_back(8'(v));
        occ++;
      end
    end
    check("ovf_tx_full", 32'(tx_full), 32'(1));
    expect_tx("ovf");
    check("ovf_drained", 32'(tx_empty), 32'(1));

    // RX overflow: five frames with no reads.
    for (int j = 0; j < 5; j++) begin
      d = 8'($urandom);
      send_rx(d, 1'b1);
      if (rx_model.size() < DEPTH) rx_model.push_back(d);
    end
    check("rxovf_full", 32'(rx_full), 32'(1));
    while (rx_model.size() > 0) rx_pop_check("rxovf_data", rx_model.pop_front());
    check("rxovf_empty", 32'(rx_empty), 32'(1));

    // Randomized traffic on both sides.
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(1, DEPTH);
      for (int j = 0; j < k; j++) begin
        d = 8'($urandom);
        tx_push(d);
        exp_q.push_back(d);
      end
      expect_tx($sformatf("rand_tx%0d", it));

      k = $urandom_range(1, DEPTH + 1);
      for (int j = 0; j < k; j++) begin
        d = 8'($urandom);
        good = ($urandom_range(0, 3) != 0);
        if (!good) d = d | 8'h01;
        send_rx(d, good);
        if (good && rx_model.size() < DEPTH) rx_model.push_back(d);
      end
      while (rx_model.size() > 0) rx_pop_check($sformatf("rand_rx%0d", it), rx_model.pop_front());
      check("rand_rx_empty", 32'(rx_empty), 32'(1));
    end

    // Break: line low for 12 bit times, then recovery with a normal frame.
    check("pre_break_cnt", 32'(break_cnt), 32'(0));
    rx = 1'b0;
    repeat (12*CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3*CPB) @(negedge clk);
    check("break_pulses", 32'(break_cnt), 32'(1));
    check("break_rx_empty", 32'(rx_empty), 32'(1));
    send_rx(8'h5A, 1'b1);
    rx_pop_check("post_break_data", 8'h5A);
    check("tx_framing_errors", 32'(tx_ferr), 32'(0));

    // Reset asserted during a start bit.
    tx_push(8'h00);
    wait_tx_low("midreset_start_seen");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_tx_high", 32'(tx), 32'(1));
    check("midreset_tx_empty", 32'(tx_empty), 32'(1));
    reset = 1'b0;
    repeat (150) @(negedge clk);
    check("midreset_line_idle", 32'({tx, tx_empty}), 32'(2'b11));
    tx_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
